// File: rtl/exec_unit_if.sv
// ctrl_bus_if: shared control bus carrying the single clock and the
// synchronous active-high reset to the execute stage.
interface ctrl_bus_if;
  logic clk;
  logic rst;
  modport master (input clk, input rst);
endinterface

// File: rtl/exec_unit.sv
// exec_unit: handshaked execute stage holding A, B, OUT, PC, carry, zero.
// Ports: ctrl (clk/rst), op_valid/op_ready, opcode, imm, in -> reg_a,
// reg_b, out_port, pc, carry, zero, done (one-cycle retire pulse).
module exec_unit #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4,
  parameter bit MUL_EN = 1'b1
) (
  ctrl_bus_if.master          ctrl,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [3:0]          opcode,
  input  logic [DATA_W-1:0]   imm,
  input  logic [DATA_W-1:0]   in,
  output logic [DATA_W-1:0]   reg_a,
  output logic [DATA_W-1:0]   reg_b,
  output logic [DATA_W-1:0]   out_port,
  output logic [PC_W-1:0]     pc,
  output logic                carry,
  output logic                zero,
  output logic                done
);

  localparam int CW = $clog2(DATA_W);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_MOV_AB = 4'h0;
  localparam logic [3:0] OP_MOV_BA = 4'h1;
  localparam logic [3:0] OP_MOV_AI = 4'h2;
  localparam logic [3:0] OP_MOV_BI = 4'h3;
  localparam logic [3:0] OP_IN_A   = 4'h4;
  localparam logic [3:0] OP_IN_B   = 4'h5;
  localparam logic [3:0] OP_OUT_B  = 4'h6;
  localparam logic [3:0] OP_OUT_I  = 4'h7;
  localparam logic [3:0] OP_ADD_A  = 4'h8;
  localparam logic [3:0] OP_ADD_B  = 4'h9;
  localparam logic [3:0] OP_JMP    = 4'hA;
  localparam logic [3:0] OP_JNC    = 4'hB;
  localparam logic [3:0] OP_JZ     = 4'hC;
  localparam logic [3:0] OP_SUB    = 4'hD;
  localparam logic [3:0] OP_MUL    = 4'hE;
  localparam logic [3:0] OP_NOP    = 4'hF;

  logic [0:0]          r_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_out;
  logic [PC_W-1:0]     r_pc;
  logic                r_carry;
  logic                r_zero;
  logic                r_done;
  logic [2*DATA_W-1:0] r_mc;
  logic [DATA_W-1:0]   r_mp;
  logic [2*DATA_W-1:0] r_acc;
  logic [CW-1:0]       r_cnt;

  logic [DATA_W-1:0]   w_add_src;
  logic [DATA_W:0]     w_add;
  logic [DATA_W-1:0]   w_sub;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_pc_imm;
  logic [2*DATA_W-1:0] w_acc_nx;
  logic                w_last;

  assign w_add_src = (opcode == OP_ADD_B) ? r_b : r_a;
  assign w_add     = {1'b0, w_add_src} + {1'b0, imm};
  assign w_sub     = r_a - r_b;
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_pc_imm  = PC_W'(imm);
  // Shift-add: multiplicand shifts left, multiplier shifts right.
  assign w_acc_nx  = r_mp[0] ? (r_acc + r_mc) : r_acc;
  assign w_last    = (r_cnt == CW'(DATA_W - 1));

  always_ff @(posedge ctrl.clk) begin
    if (ctrl.rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_pc    <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_mc    <= '0;
      r_mp    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_pc    <= w_pc_inc;
            r_carry <= 1'b0;
            r_done  <= 1'b1;
            unique case (opcode)
              OP_MOV_AB: r_a   <= r_b;
              OP_MOV_BA: r_b   <= r_a;
              OP_MOV_AI: r_a   <= imm;
              OP_MOV_BI: r_b   <= imm;
              OP_IN_A:   r_a   <= in;
              OP_IN_B:   r_b   <= in;
              OP_OUT_B:  r_out <= r_b;
              OP_OUT_I:  r_out <= imm;
              OP_ADD_A: begin
                r_a     <= w_add[DATA_W-1:0];
                r_carry <= w_add[DATA_W];
                r_zero  <= (w_add[DATA_W-1:0] == '0);
              end
              OP_ADD_B: begin
                r_b     <= w_add[DATA_W-1:0];
                r_carry <= w_add[DATA_W];
                r_zero  <= (w_add[DATA_W-1:0] == '0);
              end
              OP_JMP: r_pc <= w_pc_imm;
              OP_JNC: if (!r_carry) r_pc <= w_pc_imm;
              OP_JZ:  if (r_zero) r_pc <= w_pc_imm;
              OP_SUB: begin
                r_a     <= w_sub;
                r_carry <= (r_a < r_b);
                r_zero  <= (w_sub == '0);
              end
              OP_MUL: begin
                // Without the multiplier this is a plain NOP.
                if (MUL_EN) begin
                  r_pc    <= r_pc;
                  r_carry <= r_carry;
                  r_done  <= 1'b0;
                  r_mc    <= {{DATA_W{1'b0}}, r_a};
                  r_mp    <= r_b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_MUL;
                end
              end
              OP_NOP: ;
            endcase
          end
        end
        S_MUL: begin
          r_acc <= w_acc_nx;
          r_mc  <= r_mc << 1;
          r_mp  <= r_mp >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_a     <= w_acc_nx[DATA_W-1:0];
            r_b     <= w_acc_nx[2*DATA_W-1:DATA_W];
            r_carry <= (w_acc_nx[2*DATA_W-1:DATA_W] != '0);
            r_zero  <= (w_acc_nx == '0);
            r_pc    <= w_pc_inc;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign op_ready = (r_state == S_IDLE);
  assign reg_a    = r_a;
  assign reg_b    = r_b;
  assign out_port = r_out;
  assign pc       = r_pc;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign done     = r_done;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: randomized scoreboard bench for exec_unit against an
// arithmetic reference model; extra instances cover DATA_W=8 and MUL_EN=0.
module tb_exec_unit;
  localparam int DW = 4;
  localparam int PW = 4;

  typedef struct {
    int a; int b; int o; int pc; bit c; bit z;
  } st_t;
  typedef struct {
    st_t s; int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_bus_if cb ();
  assign cb.clk = clk;
  assign cb.rst = rst;

  logic          op_valid, op_ready, carry, zero, done;
  logic [3:0]    opcode;
  logic [DW-1:0] imm, in_v, reg_a, reg_b, out_port;
  logic [PW-1:0] pc;

  exec_unit #(.DATA_W(DW), .PC_W(PW), .MUL_EN(1'b1)) u_dut (
    .ctrl(cb.master), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .imm(imm), .in(in_v), .reg_a(reg_a),
    .reg_b(reg_b), .out_port(out_port), .pc(pc), .carry(carry),
    .zero(zero), .done(done));

  logic       v8, rdy8, c8, z8, d8;
  logic [3:0] op8;
  logic [7:0] imm8, in8, a8, b8, o8, pc8;

  exec_unit #(.DATA_W(8), .PC_W(8), .MUL_EN(1'b1)) u_w8 (
    .ctrl(cb.master), .op_valid(v8), .op_ready(rdy8), .opcode(op8),
    .imm(imm8), .in(in8), .reg_a(a8), .reg_b(b8), .out_port(o8),
    .pc(pc8), .carry(c8), .zero(z8), .done(d8));

  logic       v0, rdy0, c0, z0, d0;
  logic [3:0] op0, imm0, in0, a0, b0, o0, pc0;

  exec_unit #(.DATA_W(4), .PC_W(4), .MUL_EN(1'b0)) u_nm (
    .ctrl(cb.master), .op_valid(v0), .op_ready(rdy0), .opcode(op0),
    .imm(imm0), .in(in0), .reg_a(a0), .reg_b(b0), .out_port(o0),
    .pc(pc0), .carry(c0), .zero(z0), .done(d0));

  exp_t q[$];
  st_t  mst, mst8, mst0;
  int   vecs = 0;
  int   fails = 0;
  int   ncyc = 0;
  int   run = 0;
  bit   abort_run = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Reference: architectural effect of one instruction.
  function automatic st_t model(st_t s, int op, int im, int iv,
                                int dw, int pw, bit mulen);
    st_t n;
    int  m, pm, t;
    m  = 1 << dw;
    pm = 1 << pw;
    n  = s;
    n.pc = (s.pc + 1) % pm;
    n.c  = 1'b0;
    case (op)
      0: n.a = s.b;
      1: n.b = s.a;
      2: n.a = im;
      3: n.b = im;
      4: n.a = iv;
      5: n.b = iv;
      6: n.o = s.b;
      7: n.o = im;
      8: begin
        t = s.a + im; n.a = t % m; n.c = (t >= m); n.z = (n.a == 0);
      end
      9: begin
        t = s.b + im; n.b = t % m; n.c = (t >= m); n.z = (n.b == 0);
      end
      10: n.pc = im % pm;
      11: if (!s.c) n.pc = im % pm;
      12: if (s.z) n.pc = im % pm;
      13: begin
        n.a = (s.a - s.b + m) % m; n.c = (s.a < s.b); n.z = (n.a == 0);
      end
      14: if (mulen) begin
        t = s.a * s.b;
        n.a = t % m; n.b = t / m; n.c = (t >= m); n.z = (t == 0);
      end
      default: ;
    endcase
    return n;
  endfunction

  // Monitor: busy-window length and retirement scoreboard.
  always @(negedge clk) begin
    ncyc++;
    if (mon_en) begin
      if (!op_ready) run++;
      else if (run != 0) begin
        if (!abort_run) chk("ready_low_cycles", run, DW);
        run = 0;
        abort_run = 1'b0;
      end
      if (rst && !op_ready) abort_run = 1'b1;
      if (done) begin : retire
        exp_t e;
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_cycle", ncyc, e.due);
          chk("reg_a", reg_a, e.s.a);
          chk("reg_b", reg_b, e.s.b);
          chk("out_port", out_port, e.s.o);
          chk("pc", pc, e.s.pc);
          chk("carry", carry, e.s.c);
          chk("zero", zero, e.s.z);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input int op, input int im, input int iv);
    exp_t e;
    int   g;
    op_valid = 1'b1;
    opcode   = 4'(op);
    imm      = DW'(im);
    in_v     = DW'(iv);
    g = 0;
    while (!op_ready && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!op_ready) begin
      chk("ready_timeout", 0, 1);
      op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.s = model(mst, op, im, iv, DW, PW, 1'b1);
    mst = e.s;
    e.due = ncyc + 1 + ((op == 14) ? DW : 0);
    q.push_back(e);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic drv8(input int op, input int im);
    v8 = 1'b1; op8 = 4'(op); imm8 = 8'(im);
    @(posedge clk);
    mst8 = model(mst8, op, im, 0, 8, 8, 1'b1);
    #1 v8 = 1'b0;
  endtask

  task automatic drv0(input int op, input int im);
    v0 = 1'b1; op0 = 4'(op); imm0 = 4'(im);
    @(posedge clk);
    mst0 = model(mst0, op, im, 0, 4, 4, 1'b0);
    #1 v0 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    op_valid = 1'b1; opcode = 4'h2; imm = 4'h5; in_v = '0;
    v8 = 1'b0; op8 = '0; imm8 = '0; in8 = '0;
    v0 = 1'b0; op0 = '0; imm0 = '0; in0 = '0;
    mst  = '{default: 0};
    mst8 = '{default: 0};
    mst0 = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    chk("rst_a", reg_a, 0);
    chk("rst_b", reg_b, 0);
    chk("rst_out", out_port, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", {carry, zero}, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_pc8", pc8, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    issue(2, 9, 0); issue(8, 9, 0); issue(11, 5, 0); issue(11, 5, 0);
    issue(2, 3, 0); issue(3, 5, 0); issue(13, 0, 0);
    issue(2, 5, 0); issue(13, 0, 0); issue(12, 12, 0);
    issue(2, 7, 0); issue(3, 6, 0); issue(14, 0, 0); issue(9, 1, 0);
    issue(2, 0, 0); issue(14, 0, 0);
    issue(6, 0, 0); issue(7, 3, 0); issue(4, 0, 11); issue(5, 0, 4);
    repeat (3) @(posedge clk);
    #1;

    issue(2, 3, 0); issue(3, 4, 0); issue(14, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    mst = '{default: 0};
    @(negedge clk);
    chk("abort_a", reg_a, 0);
    chk("abort_b", reg_b, 0);
    chk("abort_pc", pc, 0);
    chk("abort_ready", op_ready, 1);
    chk("abort_done", done, 0);
    @(posedge clk);
    #1;

    issue(10, 15, 0); issue(15, 0, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue($urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15));
    end
    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
    chk("drain", q.size(), 0);

    @(posedge clk);
    #1;
    drv8(2, 200); drv8(3, 3); drv8(14, 0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!rdy8) n++;
      if (d8) break;
    end
    chk("w8_done", d8, 1);
    chk("w8_ready_low", n, 8);
    chk("w8_a", a8, mst8.a);
    chk("w8_b", b8, mst8.b);
    chk("w8_carry", c8, mst8.c);
    chk("w8_zero", z8, mst8.z);
    chk("w8_pc", pc8, mst8.pc);
    @(posedge clk);
    #1;

    drv0(2, 7); drv0(3, 6); drv0(8, 12); drv0(14, 0);
    @(negedge clk);
    chk("nm_done", d0, 1);
    chk("nm_ready", rdy0, 1);
    chk("nm_a", a0, mst0.a);
    chk("nm_b", b0, mst0.b);
    chk("nm_carry", c0, mst0.c);
    chk("nm_zero", z0, mst0.z);
    chk("nm_pc", pc0, mst0.pc);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
